// File: rtl/conv_sequencer.sv
// Run-level sequencer for the convolution datapath: releases memory, then the selected
// engines in order, then the display, with busy/done handshake and a completed-run counter.
module conv_sequencer #(
    parameter int unsigned MEM_CYCLES = 4,
    parameter int unsigned PE_CYCLES  = 20,
    parameter int unsigned S3_CYCLES  = 12,
    parameter int unsigned S2_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] mode,
    output logic       rst_mem,
    output logic       rst_pe,
    output logic       rst_3b3,
    output logic       rst_2b2,
    output logic       rst_disp,
    output logic       busy,
    output logic       done,
    output logic [2:0] state,
    output logic [7:0] run_cnt
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StRunPe  = 3'd2,
        StRun3b3 = 3'd3,
        StRun2b2 = 3'd4,
        StDisp   = 3'd5
    } state_e;

    localparam logic [7:0] MemLast = 8'(MEM_CYCLES - 1);
    localparam logic [7:0] PeLast  = 8'(PE_CYCLES - 1);
    localparam logic [7:0] S3Last  = 8'(S3_CYCLES - 1);
    localparam logic [7:0] S2Last  = 8'(S2_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [1:0] mode_q, mode_d;
    logic       rst_mem_q, rst_mem_d;
    logic       rst_pe_q, rst_pe_d;
    logic       rst_3b3_q, rst_3b3_d;
    logic       rst_2b2_q, rst_2b2_d;
    logic       rst_disp_q, rst_disp_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] run_cnt_q, run_cnt_d;
    state_e     first_run;
    logic       hold_engines;

    always_comb begin
        first_run = StRunPe;
        case (mode_q)
            2'b10:   first_run = StRun3b3;
            2'b11:   first_run = StRun2b2;
            default: first_run = StRunPe;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    mode_d  = mode;
                end
            end
            StLoad: begin
                if (phase_q == MemLast) state_d = first_run;
            end
            StRunPe: begin
                if (phase_q == PeLast) state_d = (mode_q == 2'b00) ? StRun3b3 : StDisp;
            end
            StRun3b3: begin
                if (phase_q == S3Last) state_d = (mode_q == 2'b00) ? StRun2b2 : StDisp;
            end
            StRun2b2: begin
                if (phase_q == S2Last) state_d = StDisp;
            end
            StDisp: begin
                if (start) begin
                    state_d = StLoad;
                    mode_d  = mode;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort wins over any start, including a restart from DISP.
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            mode_d  = mode_q;
        end
    end

    always_comb begin
        phase_d = (state_d != state_q) ? 8'd0 : phase_q + 8'd1;

        // An engine that has been released stays released until LOAD or IDLE.
        hold_engines = (state_d == StRun3b3) || (state_d == StRun2b2) || (state_d == StDisp);

        rst_mem_d  = (state_d != StIdle);
        rst_pe_d   = (state_d == StRunPe) || (rst_pe_q && hold_engines);
        rst_3b3_d  = (state_d == StRun3b3) || (rst_3b3_q && hold_engines);
        rst_2b2_d  = (state_d == StRun2b2) || (rst_2b2_q && hold_engines);
        rst_disp_d = (state_d == StDisp);
        busy_d     = (state_d == StLoad) || (state_d == StRunPe) ||
                     (state_d == StRun3b3) || (state_d == StRun2b2);
        done_d     = (state_d == StDisp) && (state_q != StDisp);
        run_cnt_d  = done_d ? run_cnt_q + 8'd1 : run_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            phase_q    <= 8'd0;
            mode_q     <= 2'b00;
            rst_mem_q  <= 1'b0;
            rst_pe_q   <= 1'b0;
            rst_3b3_q  <= 1'b0;
            rst_2b2_q  <= 1'b0;
            rst_disp_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            run_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            mode_q     <= mode_d;
            rst_mem_q  <= rst_mem_d;
            rst_pe_q   <= rst_pe_d;
            rst_3b3_q  <= rst_3b3_d;
            rst_2b2_q  <= rst_2b2_d;
            rst_disp_q <= rst_disp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    assign state    = state_q;
    assign rst_mem  = rst_mem_q;
    assign rst_pe   = rst_pe_q;
    assign rst_3b3  = rst_3b3_q;
    assign rst_2b2  = rst_2b2_q;
    assign rst_disp = rst_disp_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign run_cnt  = run_cnt_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: default-budget instance plus an all-ones-budget instance
// driven by the same controls.
module tb_conv_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] mode;

    logic       rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp, busy, done;
    logic [2:0] state;
    logic [7:0] run_cnt;

    logic       f_rst_mem, f_rst_pe, f_rst_3b3, f_rst_2b2, f_rst_disp, f_busy, f_done;
    logic [2:0] f_state;
    logic [7:0] f_run_cnt;

    int checks;
    int errors;

    conv_sequencer u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .rst_mem  (rst_mem),
        .rst_pe   (rst_pe),
        .rst_3b3  (rst_3b3),
        .rst_2b2  (rst_2b2),
        .rst_disp (rst_disp),
        .busy     (busy),
        .done     (done),
        .state    (state),
        .run_cnt  (run_cnt)
    );

    conv_sequencer #(
        .MEM_CYCLES (1),
        .PE_CYCLES  (1),
        .S3_CYCLES  (1),
        .S2_CYCLES  (1)
    ) u_dut_fast (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .rst_mem  (f_rst_mem),
        .rst_pe   (f_rst_pe),
        .rst_3b3  (f_rst_3b3),
        .rst_2b2  (f_rst_2b2),
        .rst_disp (f_rst_disp),
        .busy     (f_busy),
        .done     (f_done),
        .state    (f_state),
        .run_cnt  (f_run_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge e counts from the edge that samples start (e = 0); default budgets 4/20/12/16.
    task automatic trace(input logic [1:0] m, input bit hold, input int last_e);
        int pe_len, s3_len, s2_len, b1, b2, b3, b4, es;
        pe_len = (m == 2'b00 || m == 2'b01) ? 20 : 0;
        s3_len = (m == 2'b00 || m == 2'b10) ? 12 : 0;
        s2_len = (m == 2'b00 || m == 2'b11) ? 16 : 0;
        b1 = 4;
        b2 = b1 + pe_len;
        b3 = b2 + s3_len;
        b4 = b3 + s2_len;
        for (int e = 0; e <= last_e; e++) begin
            tick();
            if (e == 0 && !hold) start = 1'b0;
            es = (e < b1) ? 1 : (e < b2) ? 2 : (e < b3) ? 3 : (e < b4) ? 4 : 5;
            check($sformatf("m%0d_e%0d_state", m, e), 32'(state), 32'(es));
            check($sformatf("m%0d_e%0d_busy", m, e), 32'(busy), 32'(e < b4));
            check($sformatf("m%0d_e%0d_done", m, e), 32'(done), 32'(e == b4));
            check($sformatf("m%0d_e%0d_rst_mem", m, e), 32'(rst_mem), 32'd1);
            check($sformatf("m%0d_e%0d_rst_pe", m, e), 32'(rst_pe),
                  32'(pe_len > 0 && e >= b1));
            check($sformatf("m%0d_e%0d_rst_3b3", m, e), 32'(rst_3b3),
                  32'(s3_len > 0 && e >= b2));
            check($sformatf("m%0d_e%0d_rst_2b2", m, e), 32'(rst_2b2),
                  32'(s2_len > 0 && e >= b3));
            check($sformatf("m%0d_e%0d_rst_disp", m, e), 32'(rst_disp), 32'(e >= b4));
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp, busy, done, state, run_cnt});
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mode   = 2'b00;

        // Reset values
        #12;
        check("reset_outs", outs(), 32'd0);
        check("reset_fast_state", 32'(f_state), 32'd0);
        rst = 1'b1;
        tick();
        check("idle_outs", outs(), 32'd0);

        // Abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_state", 32'(state), 32'd0);

        // Mode 00 full run
        mode  = 2'b00;
        start = 1'b1;
        trace(2'b00, 1'b0, 52);
        tick();
        check("m0_done_low", 32'(done), 32'd0);
        check("m0_stay_disp", 32'(state), 32'd5);
        check("m0_run_cnt", 32'(run_cnt), 32'd1);

        // Mode 10 restart from DISP
        mode  = 2'b10;
        start = 1'b1;
        trace(2'b10, 1'b0, 16);
        tick();
        check("m2_done_low", 32'(done), 32'd0);
        check("m2_run_cnt", 32'(run_cnt), 32'd2);

        // Start held high through a mode 00 run
        mode  = 2'b00;
        start = 1'b1;
        trace(2'b00, 1'b1, 52);
        check("hold_run_cnt", 32'(run_cnt), 32'd3);
        for (int e = 53; e <= 56; e++) begin
            tick();
            if (e == 53) start = 1'b0;
            check($sformatf("hold_e%0d_state", e), 32'(state), 32'd1);
            check($sformatf("hold_e%0d_engines", e), 32'({rst_pe, rst_3b3, rst_2b2, rst_disp}),
                  32'd0);
            check($sformatf("hold_e%0d_rst_mem", e), 32'(rst_mem), 32'd1);
        end
        tick();
        check("hold_e57_state", 32'(state), 32'd2);
        check("hold_e57_rst_pe", 32'(rst_pe), 32'd1);

        // Abort 30 edges into the restarted run (started at edge 53)
        repeat (25) tick();
        check("pre_abort_state", 32'(state), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outs", outs(), 32'd3);
        tick();
        check("abort_after", outs(), 32'd3);

        // Mode 01 run, then abort with start together in DISP
        mode  = 2'b01;
        start = 1'b1;
        trace(2'b01, 1'b0, 24);
        check("m1_run_cnt", 32'(run_cnt), 32'd4);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_outs", outs(), 32'd4);

        // Asynchronous reset during RUN_PE
        mode  = 2'b00;
        start = 1'b1;
        trace(2'b00, 1'b0, 6);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_outs", outs(), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        check("async_rst_idle", outs(), 32'd0);

        // 256 mode 01 runs; run_cnt wraps to 0
        mode = 2'b01;
        for (int i = 0; i < 256; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (24) tick();
            check($sformatf("wrap_done_%0d", i), 32'(done), 32'd1);
            if (i == 254) check("wrap_cnt_255", 32'(run_cnt), 32'd255);
        end
        check("wrap_cnt_0", 32'(run_cnt), 32'd0);
        check("wrap_fast_cnt_0", 32'(f_run_cnt), 32'd0);

        // All budgets 1: one cycle per phase, DISP 4 edges after start
        mode  = 2'b00;
        start = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e == 0) start = 1'b0;
            check($sformatf("fast_e%0d_state", e), 32'(f_state), 32'((e < 4) ? e + 1 : 5));
            check($sformatf("fast_e%0d_done", e), 32'(f_done), 32'(e == 4));
            check($sformatf("fast_e%0d_busy", e), 32'(f_busy), 32'(e < 4));
            check($sformatf("fast_e%0d_engines", e), 32'({f_rst_pe, f_rst_3b3, f_rst_2b2}),
                  32'({e >= 1, e >= 2, e >= 3}));
        end
        check("fast_run_cnt", 32'(f_run_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
